// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature encoder emulator and its decoder-side models.
package quad_pkg;

  localparam int COUNTS_PER_REV_DEFAULT = 1496;
  localparam int POS_W = 16;

  // {A,B} channel states in forward order: 00 -> 10 -> 11 -> 01 -> 00
  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_10 = 2'b10,
    QS_11 = 2'b11,
    QS_01 = 2'b01
  } quad_state_e;

  // Map the two LSBs of a position count to the {A,B} channel pair.
  function automatic logic [1:0] pos2ab(input logic [1:0] pos);
    quad_state_e qs;
    case (pos)
      2'd0:    qs = QS_00;
      2'd1:    qs = QS_10;
      2'd2:    qs = QS_11;
      default: qs = QS_01;
    endcase
    return qs;
  endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Control and status bundle of the quadrature encoder emulator.
interface quad_encoder_gen_if
  import quad_pkg::*;
#(
  parameter int INC_W = 16
);

  logic             en;
  logic             dir;
  logic [INC_W-1:0] step_inc;
  logic             load;
  logic [POS_W-1:0] load_pos;
  logic             quadA;
  logic             quadB;
  logic             index;
  logic [POS_W-1:0] position;
  logic             overrun;

  modport master (
    output en, dir, step_inc, load, load_pos,
    input  quadA, quadB, index, position, overrun
  );

  modport slave (
    input  en, dir, step_inc, load, load_pos,
    output quadA, quadB, index, position, overrun
  );

endinterface

// File: rtl/quad_nco.sv
// Phase accumulator; each carry out of the MSB is one step request.
module quad_nco #(
  parameter int ACC_W = 24,
  parameter int INC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [INC_W-1:0] inc_i,
  output logic             carry_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  assign sum     = {1'b0, acc_q} + (ACC_W + 1)'(inc_i);
  assign carry_o = en_i & sum[ACC_W];

  // Next accumulator value: clear wins, otherwise advance only while enabled.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: NCO-paced A/B/index generation with edge-rate limiting.
module quad_encoder_gen
  import quad_pkg::*;
#(
  parameter int COUNTS_PER_REV = COUNTS_PER_REV_DEFAULT,
  parameter int ACC_W          = 24,
  parameter int INC_W          = 16,
  parameter int MIN_HOLD       = 4
) (
  input  logic              clk,
  input  logic              rst,
  quad_encoder_gen_if.slave ctl
);

  localparam int               HOLD_W      = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(MIN_HOLD - 1);
  localparam logic [POS_W-1:0]  POS_LAST    = POS_W'(COUNTS_PER_REV - 1);

  logic              step_req;
  logic              step;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pend_q, pend_d;
  logic              overrun_q, overrun_d;
  logic [POS_W-1:0]  pos_q, pos_d;

  logic              quad_a_q, quad_b_q, index_q;
  logic [1:0]        ab_d;

  quad_nco #(
    .ACC_W (ACC_W),
    .INC_W (INC_W)
  ) u_nco (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ctl.en),
    .clear_i (ctl.load),
    .inc_i   (ctl.step_inc),
    .carry_o (step_req)
  );

  // Step arbitration, hold timer, pending/overrun tracking and next position.
  // A load discards any same-cycle request and restarts the pacing from scratch.
  always_comb begin
    step      = 1'b0;
    hold_d    = hold_q;
    pend_d    = pend_q;
    overrun_d = overrun_q;
    pos_d     = pos_q;

    if (ctl.load) begin
      hold_d = '0;
      pend_d = 1'b0;
      if (32'(ctl.load_pos) >= 32'(COUNTS_PER_REV)) begin
        pos_d = '0;
      end else begin
        pos_d = ctl.load_pos;
      end
    end else begin
      if (hold_q == '0) begin
        if (step_req || pend_q) begin
          step   = 1'b1;
          hold_d = HOLD_RELOAD;
          // Pending edge consumed now; a simultaneous new request takes its place.
          pend_d = step_req && pend_q;
        end
      end else begin
        hold_d = hold_q - HOLD_W'(1);
        if (step_req) begin
          if (pend_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_d = 1'b1;
          end
        end
      end

      if (step) begin
        if (ctl.dir) begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else begin
          pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
        end
      end
    end
  end

  // Channel encoding derived from the next position so A/B/index move with position.
  assign ab_d = pos2ab(pos_d[1:0]);

  // Pacing and position state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      pos_q     <= '0;
    end else begin
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      pos_q     <= pos_d;
    end
  end

  // Glitch-free channel outputs straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quad_a_q <= 1'b0;
      quad_b_q <= 1'b0;
      index_q  <= 1'b1;
    end else begin
      quad_a_q <= ab_d[1];
      quad_b_q <= ab_d[0];
      index_q  <= (pos_d == '0);
    end
  end

  assign ctl.quadA    = quad_a_q;
  assign ctl.quadB    = quad_b_q;
  assign ctl.index    = index_q;
  assign ctl.position = pos_q;
  assign ctl.overrun  = overrun_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Scoreboard bench: main instance at full accumulator width, second instance with a
// 17-bit accumulator to reach hold/overrun behaviour and run a decoder loopback.
module tb_quad_encoder_gen;

  localparam int CPR = 1496;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  quad_encoder_gen_if #(.INC_W(16)) bus ();
  quad_encoder_gen_if #(.INC_W(16)) bus2 ();

  quad_encoder_gen #(
    .COUNTS_PER_REV (CPR),
    .ACC_W          (24),
    .INC_W          (16),
    .MIN_HOLD       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  quad_encoder_gen #(
    .COUNTS_PER_REV (CPR),
    .ACC_W          (17),
    .INC_W          (16),
    .MIN_HOLD       (4)
  ) dut2 (
    .clk (clk),
    .rst (rst2),
    .ctl (bus2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] ab_of(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // ---------------- main instance scoreboard ----------------
  typedef struct {
    int     pos;
    longint spc;   // required cycles since previous output change, 0 = not checked
  } exp_t;

  exp_t       sbq[$];
  exp_t       e_m;
  int         ev_main = 0;
  int         prev_pos = 0;
  logic [1:0] prev_ab = 2'b00;
  longint     last_ev = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_pos = int'(bus.position);
      prev_ab  = {bus.quadA, bus.quadB};
      last_ev  = cyc;
    end else if (int'(bus.position) != prev_pos || {bus.quadA, bus.quadB} != prev_ab) begin
      ev_main++;
      if (sbq.size() == 0) begin
        check_val("unexpected_change", longint'(bus.position), -1);
      end else begin
        e_m = sbq.pop_front();
        check_val("position", longint'(bus.position), e_m.pos);
        check_val("ab", longint'({bus.quadA, bus.quadB}), longint'(ab_of(e_m.pos)));
        check_val("index", longint'(bus.index), (e_m.pos == 0) ? 1 : 0);
        if (e_m.spc != 0) check_val("spacing", cyc - last_ev, e_m.spc);
      end
      prev_pos = int'(bus.position);
      prev_ab  = {bus.quadA, bus.quadB};
      last_ev  = cyc;
    end
  end

  task automatic push_exp(input int p, input longint s);
    exp_t t;
    t.pos = p;
    t.spc = s;
    sbq.push_back(t);
  endtask

  task automatic wait_main(input int target, input longint budget, input string tag);
    longint t0;
    t0 = cyc;
    while (ev_main < target && (cyc - t0) < budget) begin
      @(negedge clk);
      #1;
    end
    check_val(tag, ev_main, target);
  endtask

  task automatic load_main(input int p);
    @(negedge clk);
    #1;
    bus.load     = 1'b1;
    bus.load_pos = 16'(p);
    @(negedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  // ---------------- second instance monitor ----------------
  int         ev2 = 0;
  int         prev_pos2 = 0;
  logic [1:0] prev_ab2 = 2'b00;
  longint     last2 = 0;
  bit         spc_on2 = 1'b0;
  longint     spc_exp2 = 0;
  bit         loop_on = 1'b0;
  int         dec_cnt = 0;
  int         dstep;
  bit         done2 = 1'b0;

  always @(negedge clk) begin
    if (rst2) begin
      prev_pos2 = int'(bus2.position);
      prev_ab2  = {bus2.quadA, bus2.quadB};
      last2     = cyc;
    end else if (int'(bus2.position) != prev_pos2 || {bus2.quadA, bus2.quadB} != prev_ab2) begin
      ev2++;
      if (spc_on2) check_val("spacing2", cyc - last2, spc_exp2);
      if (loop_on) begin
        dstep = (gray_idx({bus2.quadA, bus2.quadB}) - gray_idx(prev_ab2)) & 3;
        if (dstep == 1) begin
          dec_cnt = (dec_cnt == CPR - 1) ? 0 : dec_cnt + 1;
        end else if (dstep == 3) begin
          dec_cnt = (dec_cnt == 0) ? CPR - 1 : dec_cnt - 1;
        end else begin
          check_val("decoder_illegal_jump", dstep, 1);
        end
        check_val("loopback", longint'(bus2.position), dec_cnt);
      end
      prev_pos2 = int'(bus2.position);
      prev_ab2  = {bus2.quadA, bus2.quadB};
      last2     = cyc;
    end
  end

  task automatic wait_ev2(input int target, input longint budget, input string tag);
    longint t0;
    t0 = cyc;
    while (ev2 < target && (cyc - t0) < budget) begin
      @(negedge clk);
      #1;
    end
    check_val(tag, ev2, target);
  endtask

  // Hold/overrun, loopback and async reset on the narrow-accumulator instance.
  initial begin : small_thread
    int base;
    bus2.en = 1'b0; bus2.dir = 1'b1; bus2.step_inc = '0; bus2.load = 1'b0; bus2.load_pos = '0;
    repeat (3) @(negedge clk);
    #1;
    rst2 = 1'b0;
    bus2.step_inc = 16'hFFFF;
    bus2.en = 1'b1;
    wait_ev2(2, 200, "fast_first_edges");
    spc_exp2 = 4;
    spc_on2  = 1'b1;
    wait_ev2(30, 400, "fast_edges");
    check_val("overrun_set", longint'(bus2.overrun), 1);
    check_val("fast_position", longint'(bus2.position), 30);

    bus2.en = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    spc_on2 = 1'b0;
    bus2.load = 1'b1; bus2.load_pos = 16'd0; bus2.step_inc = 16'h4000; bus2.en = 1'b1;
    @(negedge clk);
    #1;
    bus2.load = 1'b0;
    base     = ev2;
    dec_cnt  = 0;
    loop_on  = 1'b1;
    spc_exp2 = 8;
    spc_on2  = 1'b1;
    wait_ev2(base + 3000, 3000 * 8 + 100, "loop_fwd_edges");
    bus2.dir = 1'b0;
    wait_ev2(base + 3500, 500 * 8 + 100, "loop_rev_edges");
    bus2.en = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check_val("loop_final_pos", longint'(bus2.position), 1004);
    check_val("loop_final_dec", dec_cnt, 1004);
    check_val("loop_no_extra", ev2, base + 3500);
    loop_on = 1'b0;
    spc_on2 = 1'b0;

    bus2.load = 1'b1; bus2.load_pos = 16'd37; bus2.en = 1'b1; bus2.dir = 1'b1;
    @(negedge clk);
    #1;
    bus2.load = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("pre_reset_pos", longint'(bus2.position), 37);
    #1;
    rst2 = 1'b1;
    #1;
    check_val("rst2_position", longint'(bus2.position), 0);
    check_val("rst2_quadA", longint'(bus2.quadA), 0);
    check_val("rst2_quadB", longint'(bus2.quadB), 0);
    check_val("rst2_index", longint'(bus2.index), 1);
    check_val("rst2_overrun", longint'(bus2.overrun), 0);
    done2 = 1'b1;
  end

  // Main instance sequence.
  initial begin : main_thread
    longint t0;
    bus.en = 1'b0; bus.dir = 1'b1; bus.step_inc = '0; bus.load = 1'b0; bus.load_pos = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_position", longint'(bus.position), 0);
    check_val("rst_quadA", longint'(bus.quadA), 0);
    check_val("rst_quadB", longint'(bus.quadB), 0);
    check_val("rst_index", longint'(bus.index), 1);
    check_val("rst_overrun", longint'(bus.overrun), 0);
    rst = 1'b0;

    // forward rate: one edge per 1024 clocks
    push_exp(1, 0); push_exp(2, 1024); push_exp(3, 1024); push_exp(4, 1024);
    bus.dir = 1'b1;
    bus.step_inc = 16'h4000;
    bus.en = 1'b1;
    wait_main(4, 5000, "fwd_edges");

    // load collides with the carry 1024 clocks after the previous load
    push_exp(5, 0); push_exp(0, 1024); push_exp(1, 1024);
    bus.load = 1'b1; bus.load_pos = 16'd5;
    @(negedge clk);
    #1;
    bus.load = 1'b0;
    repeat (1023) @(negedge clk);
    #1;
    bus.load = 1'b1; bus.load_pos = 16'd2000;
    @(negedge clk);
    #1;
    bus.load = 1'b0;
    wait_main(7, 3000, "collision_edges");
    check_val("collision_overrun", longint'(bus.overrun), 0);

    // wrap forward then backward
    push_exp(1494, 0); push_exp(1495, 1024); push_exp(0, 1024); push_exp(1, 1024);
    load_main(1494);
    wait_main(11, 5000, "wrap_fwd_edges");
    bus.dir = 1'b0;
    push_exp(0, 1024); push_exp(1495, 1024);
    wait_main(13, 3000, "wrap_rev_edges");

    // slow rate follows the NCO period
    push_exp(100, 0); push_exp(99, 65536);
    @(negedge clk);
    #1;
    bus.load = 1'b1; bus.load_pos = 16'd100; bus.step_inc = 16'h0100;
    @(negedge clk);
    #1;
    bus.load = 1'b0;
    wait_main(15, 70000, "slow_edges");
    check_val("slow_overrun", longint'(bus.overrun), 0);

    push_exp(6, 0);
    load_main(6);
    wait_main(16, 10, "load6");
    check_val("load6_ab", longint'({bus.quadA, bus.quadB}), 2'b11);

    push_exp(37, 0);
    load_main(37);
    wait_main(17, 10, "load37");
    push_exp(0, 0);
    load_main(CPR);
    wait_main(18, 10, "load_out_of_range");

    push_exp(37, 0);
    load_main(37);
    wait_main(19, 10, "load37_again");
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_mid_position", longint'(bus.position), 0);
    check_val("rst_mid_quadA", longint'(bus.quadA), 0);
    check_val("rst_mid_quadB", longint'(bus.quadB), 0);
    check_val("rst_mid_index", longint'(bus.index), 1);
    check_val("rst_mid_overrun", longint'(bus.overrun), 0);
    check_val("scoreboard_empty", sbq.size(), 0);

    t0 = cyc;
    while (!done2 && (cyc - t0) < 40000) @(negedge clk);
    check_val("small_thread_done", longint'(done2), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
